// File: rtl/rotate_sequencer.sv
// rtl/rotate_sequencer.sv - multi-cycle rotate controller around a bounded-step rotate datapath
//
// Purpose
//   rotate_sequencer accepts one rotate request at a time with a count of up to
//   2^CNT_WIDTH-1 positions. It breaks that count into steps of at most
//   BUS_WIDTH-1 positions, one per clock, through a single rotate_shift datapath.
//   The result is returned on a valid/ready response port.
//
// Ports (rotate_sequencer)
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle if req_valid (IDLE and not in reset)
//   req_a      in   [BUS_WIDTH]  operand
//   req_amt    in   [CNT_WIDTH]  total rotate count
//   req_dir    in   1 = left, 0 = right
//   req_thru   in   1 = rotate through carry (BUS_WIDTH+1 bit ring)
//   req_cin    in   carry in
//   rsp_valid  out  result available
//   rsp_ready  in   consumer takes the result
//   rsp_y      out  [BUS_WIDTH]  rotated result, held until the next result
//   rsp_cout   out  final carry, held until the next result
//   busy       out  operation in flight (RUN or DONE)
//
// Ports (rotate_shift)
//   a     in   [BUS_WIDTH]        operand
//   b     in   [BUS_WIDTH_BITS+2] {thru, dir, step}
//   cin   in   carry in
//   y     out  [BUS_WIDTH]        rotated operand
//   cout  out  carry out (cin unchanged for a plain rotate)
//
// Configuration
//   ROT_SEQ_MODREDUCE_EN : when defined, the count is reduced modulo the ring
//   length at accept time, so at most two steps are needed. Results are the same
//   either way; only the latency changes.

module rotate_shift #(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3
) (
  input  logic [BUS_WIDTH-1:0]      a,
  input  logic [BUS_WIDTH_BITS+1:0] b,
  input  logic                      cin,
  output logic [BUS_WIDTH-1:0]      y,
  output logic                      cout
);

  localparam int RW = BUS_WIDTH + 1;

  logic [BUS_WIDTH_BITS-1:0] step;
  logic                      dir;
  logic                      thru;
  logic [RW-1:0]             ring;
  logic [RW-1:0]             ring_rot;
  logic [BUS_WIDTH-1:0]      plain_rot;

  assign step = b[BUS_WIDTH_BITS-1:0];
  assign dir  = b[BUS_WIDTH_BITS];
  assign thru = b[BUS_WIDTH_BITS+1];

  // Rotations are built as (x << s) | (x >> (W - s)). With s = 0 the right-hand
  // shift amount equals the width, which yields zero, so no special case is needed.
  always_comb begin
    ring = {a, cin};
    if (dir) begin
      plain_rot = (a << step) | (a >> (BUS_WIDTH - 32'(step)));
      ring_rot  = (ring << step) | (ring >> (RW - 32'(step)));
    end else begin
      plain_rot = (a >> step) | (a << (BUS_WIDTH - 32'(step)));
      ring_rot  = (ring >> step) | (ring << (RW - 32'(step)));
    end
    if (thru) begin
      y    = ring_rot[RW-1:1];
      cout = ring_rot[0];
    end else begin
      y    = plain_rot;
      cout = cin;
    end
  end

endmodule

module rotate_sequencer #(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [CNT_WIDTH-1:0] req_amt,
  input  logic                 req_dir,
  input  logic                 req_thru,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_y,
  output logic                 rsp_cout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0]      STEP_MAX_C = CNT_WIDTH'(BUS_WIDTH - 1);
  localparam logic [BUS_WIDTH_BITS-1:0] STEP_MAX_B = BUS_WIDTH_BITS'(BUS_WIDTH - 1);

  state_t                    state;
  state_t                    state_n;
  logic                      accept;
  logic [BUS_WIDTH-1:0]      acc;
  logic                      carry;
  logic [CNT_WIDTH-1:0]      remaining;
  logic                      dir_r;
  logic                      thru_r;
  logic [BUS_WIDTH-1:0]      y_r;
  logic                      cout_r;
  logic [CNT_WIDTH-1:0]      amt_eff;
  logic                      amt_zero;
  logic [BUS_WIDTH_BITS-1:0] step;
  logic                      last_step;
  logic [BUS_WIDTH_BITS+1:0] rs_b;
  logic [BUS_WIDTH-1:0]      rs_y;
  logic                      rs_cout;

`ifdef ROT_SEQ_MODREDUCE_EN
  localparam logic [CNT_WIDTH-1:0] MOD_PLAIN = CNT_WIDTH'(BUS_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MOD_THRU  = CNT_WIDTH'(BUS_WIDTH + 1);

  // A full trip around the ring is the identity, so only the residue matters.
  assign amt_eff = req_thru ? (req_amt % MOD_THRU) : (req_amt % MOD_PLAIN);
`else
  assign amt_eff = req_amt;
`endif

  assign amt_zero = (amt_eff == '0);

  // Step is min(remaining, STEP_MAX); it can never exceed remaining, so the
  // down-count cannot wrap.
  assign step      = (remaining < STEP_MAX_C) ? remaining[BUS_WIDTH_BITS-1:0] : STEP_MAX_B;
  assign last_step = (remaining <= STEP_MAX_C);
  assign rs_b      = {thru_r, dir_r, step};

  rotate_shift #(
    .BUS_WIDTH      (BUS_WIDTH),
    .BUS_WIDTH_BITS (BUS_WIDTH_BITS)
  ) u_rotate_shift (
    .a    (acc),
    .b    (rs_b),
    .cin  (carry),
    .y    (rs_y),
    .cout (rs_cout)
  );

  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign rsp_y     = y_r;
  assign rsp_cout  = cout_r;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_n = amt_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The response registers y_r/cout_r are separate from acc/carry so the last
  // result stays visible on rsp_y/rsp_cout after a new request is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      remaining <= '0;
      dir_r     <= 1'b0;
      thru_r    <= 1'b0;
      y_r       <= '0;
      cout_r    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc       <= req_a;
        carry     <= req_cin;
        remaining <= amt_eff;
        dir_r     <= req_dir;
        thru_r    <= req_thru;
        if (amt_zero) begin
          y_r    <= req_a;
          cout_r <= req_cin;
        end
      end
      if (state == S_RUN) begin
        acc       <= rs_y;
        carry     <= rs_cout;
        remaining <= remaining - CNT_WIDTH'(step);
        if (last_step) begin
          y_r    <= rs_y;
          cout_r <= rs_cout;
        end
      end
    end
  end

endmodule
